cache_2wsa: RTL and testbench

CACHE_2WSA -- requirements
Module: cache_2wsa

---
 rtl/cache_2wsa.sv | 129 ++++++++++++
 tb/tb_cache_2wsa.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cache_2wsa.sv
// 2-way set-associative write-back, write-allocate cache: 32 sets of 4-byte blocks, 16-bit byte address.
// Build option: define CACHE_LRU_EN for a per-set LRU victim bit; otherwise way 0 is evicted when both ways are valid.
module cache_2wsa (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] addr_cpu,
  input  logic        rd_cpu,
  input  logic        wr_cpu,
  inout  wire  [7:0]  data_cpu,
  output logic        stall_cpu,
  output logic [15:0] addr_mem,
  output logic        rd_mem,
  output logic        wr_mem,
  inout  wire  [7:0]  data_mem,
  input  logic        ready_mem
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t           state;
  logic [1:0]       beat;
  logic [7:0]       blk [2][32][4];
  logic [8:0]       tag_arr [2][32];
  logic [1:0][31:0] vld, dirty;
  logic             victim_q;
  logic [8:0]       tag_q;
  logic [4:0]       idx_q;
`ifdef CACHE_LRU_EN
  logic [31:0]      lru;
`endif

  logic [8:0] tag;
  logic [4:0] idx;
  logic [1:0] off;
  logic [1:0] hit_w;
  logic       hit, hit_way, req, victim, cpu_oe;

  assign tag = addr_cpu[15:7];
  assign idx = addr_cpu[6:2];
  assign off = addr_cpu[1:0];
  assign req = rd_cpu | wr_cpu;

  always_comb begin
    hit_w[0] = vld[0][idx] && (tag_arr[0][idx] == tag);
    hit_w[1] = vld[1][idx] && (tag_arr[1][idx] == tag);
    hit      = |hit_w;
    hit_way  = ~hit_w[0];
    // Fill an invalid way first (way 0 before way 1), else fall back to the policy choice.
`ifdef CACHE_LRU_EN
    victim = vld[0][idx] & (~vld[1][idx] | lru[idx]);
`else
    victim = vld[0][idx] & ~vld[1][idx] ? 1'b1 : 1'b0;
`endif
  end

  always_comb begin
    rd_mem   = (state == ALLOCATE);
    wr_mem   = (state == WRITEBACK);
    addr_mem = addr_cpu;
    case (state)
      WRITEBACK: addr_mem = {tag_arr[victim_q][idx_q], idx_q, beat};
      ALLOCATE:  addr_mem = {tag_q, idx_q, beat};
      default:   addr_mem = addr_cpu;
    endcase
    // Reset forces the CPU side quiet even while a request is still held.
    stall_cpu = reset_n && ((state != IDLE) || (req && !hit));
    cpu_oe    = reset_n && (state == IDLE) && rd_cpu && !wr_cpu && hit;
  end

  assign data_cpu = cpu_oe ? blk[hit_way][idx][off] : 8'hzz;
  assign data_mem = wr_mem ? blk[victim_q][idx_q][beat] : 8'hzz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      beat     <= 2'd0;
      vld      <= '0;
      dirty    <= '0;
      victim_q <= 1'b0;
      tag_q    <= '0;
      idx_q    <= '0;
`ifdef CACHE_LRU_EN
      lru      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          if (hit) begin
            if (wr_cpu) dirty[hit_way][idx] <= 1'b1;
`ifdef CACHE_LRU_EN
            lru[idx] <= ~hit_way;
`endif
          end else begin
            victim_q <= victim;
            tag_q    <= tag;
            idx_q    <= idx;
            beat     <= 2'd0;
            state    <= (vld[victim][idx] && dirty[victim][idx]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (!ready_mem) begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= ALLOCATE;
        end
        ALLOCATE: if (!ready_mem) begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            vld[victim_q][idx_q]   <= 1'b1;
            dirty[victim_q][idx_q] <= 1'b0;
`ifdef CACHE_LRU_EN
            lru[idx_q] <= ~victim_q;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; validity bits alone qualify them.
  always_ff @(posedge clock) begin
    if (state == IDLE && wr_cpu && hit)
      blk[hit_way][idx][off] <= data_cpu;
    if (state == ALLOCATE && !ready_mem) begin
      blk[victim_q][idx_q][beat] <= data_mem;
      if (beat == 2'd3) tag_arr[victim_q][idx_q] <= tag_q;
    end
  end
endmodule

// File: tb/tb_cache_2wsa.sv
// Scoreboard bench for cache_2wsa: stimulus queues expected CPU read bytes and memory beats, monitor pops and compares.
module tb_cache_2wsa;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [15:0] addr_cpu = '0;
  logic        rd_cpu = 1'b0, wr_cpu = 1'b0, cpu_oe = 1'b0, mem_hold = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  wire  [7:0]  data_cpu, data_mem;
  logic        stall_cpu, rd_mem, wr_mem, ready_mem;
  logic [15:0] addr_mem;
  logic [7:0]  mem [0:65535];

  typedef struct packed {logic wr; logic [15:0] addr; logic [7:0] data;} beat_t;
  logic [7:0] rd_q[$];
  beat_t      mem_q[$];
  int tests = 0, fails = 0;

  cache_2wsa dut (
    .clock(clock), .reset_n(reset_n), .addr_cpu(addr_cpu), .rd_cpu(rd_cpu), .wr_cpu(wr_cpu),
    .data_cpu(data_cpu), .stall_cpu(stall_cpu), .addr_mem(addr_mem), .rd_mem(rd_mem),
    .wr_mem(wr_mem), .data_mem(data_mem), .ready_mem(ready_mem)
  );

  assign data_cpu  = cpu_oe ? cpu_wdata : 8'hzz;
  assign data_mem  = rd_mem ? mem[addr_mem] : 8'hzz;
  assign ready_mem = ~((rd_mem | wr_mem) & ~mem_hold);

  always #5 clock = ~clock;

  always @(posedge clock) if (wr_mem && !ready_mem) mem[addr_mem] <= data_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    logic [7:0] e;
    beat_t b;
    if (reset_n) begin
      if (rd_cpu && !wr_cpu && !stall_cpu) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: addr %0h data %0h", addr_cpu, data_cpu);
        end else begin
          e = rd_q.pop_front();
          chk("rd_data", {24'h0, data_cpu}, {24'h0, e});
        end
      end
      if ((rd_mem || wr_mem) && !ready_mem) begin
        if (mem_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: wr %0b addr %0h", wr_mem, addr_mem);
        end else begin
          b = mem_q.pop_front();
          chk("beat_dir", {31'h0, wr_mem}, {31'h0, b.wr});
          chk("beat_addr", {16'h0, addr_mem}, {16'h0, b.addr});
          if (b.wr) chk("wb_data", {24'h0, data_mem}, {24'h0, b.data});
        end
      end
    end
  end

  task automatic preload(input logic [15:0] base, input logic [7:0] b0, b1, b2, b3);
    mem[base] = b0; mem[base + 16'd1] = b1; mem[base + 16'd2] = b2; mem[base + 16'd3] = b3;
  endtask

  task automatic exp_fill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) mem_q.push_back('{wr: 1'b0, addr: base + 16'(i), data: 8'h00});
  endtask

  task automatic exp_wb(input logic [15:0] base, input logic [7:0] b0, b1, b2, b3);
    mem_q.push_back('{wr: 1'b1, addr: base,          data: b0});
    mem_q.push_back('{wr: 1'b1, addr: base + 16'd1,  data: b1});
    mem_q.push_back('{wr: 1'b1, addr: base + 16'd2,  data: b2});
    mem_q.push_back('{wr: 1'b1, addr: base + 16'd3,  data: b3});
  endtask

  task automatic cpu_req(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] wd);
    int n;
    @(posedge clock); #1;
    addr_cpu = a; rd_cpu = rd; wr_cpu = wr; cpu_oe = wr; cpu_wdata = wd;
    n = 0;
    do begin @(negedge clock); n++; end while (stall_cpu && n < 60);
    if (stall_cpu) begin
      tests++; fails++;
      $display("FAIL req_timeout: addr %0h still stalled after %0d cycles", a, n);
    end
    @(posedge clock); #1;
    rd_cpu = 1'b0; wr_cpu = 1'b0; cpu_oe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock); #1;
    chk("rst_stall", {31'h0, stall_cpu}, 32'h0);
    chk("rst_rd_mem", {31'h0, rd_mem}, 32'h0);
    chk("rst_wr_mem", {31'h0, wr_mem}, 32'h0);
    reset_n = 1'b1;

    // Miss with memory not ready: fill must park on beat 0.
    mem_hold = 1'b1;
    @(posedge clock); #1;
    addr_cpu = 16'h0093; rd_cpu = 1'b1;
    @(negedge clock);
    chk("miss_stall", {31'h0, stall_cpu}, 32'h1);
    chk("miss_rd_mem", {31'h0, rd_mem}, 32'h0);
    chk("miss_addr", {16'h0, addr_mem}, 32'h0093);
    repeat (4) @(negedge clock);
    chk("hold_stall", {31'h0, stall_cpu}, 32'h1);
    chk("hold_rd_mem", {31'h0, rd_mem}, 32'h1);
    chk("hold_addr", {16'h0, addr_mem}, 32'h0090);

    // Reset in the middle of the fill aborts it at once.
    @(posedge clock); #1;
    reset_n = 1'b0; #1;
    chk("abort_rd_mem", {31'h0, rd_mem}, 32'h0);
    chk("abort_stall", {31'h0, stall_cpu}, 32'h0);
    rd_cpu = 1'b0; mem_hold = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;

    preload(16'h0090, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    exp_fill(16'h0090); rd_q.push_back(8'hA3);
    cpu_req(1'b1, 1'b0, 16'h0093, 8'h00);

    preload(16'hC088, 8'h11, 8'h22, 8'h33, 8'h44);
    exp_fill(16'hC088); rd_q.push_back(8'h44);
    cpu_req(1'b1, 1'b0, 16'hC08B, 8'h00);

    rd_q.push_back(8'h11);
    cpu_req(1'b1, 1'b0, 16'hC088, 8'h00);

    cpu_req(1'b0, 1'b1, 16'hC08B, 8'h23);
    rd_q.push_back(8'h23);
    cpu_req(1'b1, 1'b0, 16'hC08B, 8'h00);

    preload(16'hC108, 8'h55, 8'h66, 8'h77, 8'h88);
    exp_fill(16'hC108); rd_q.push_back(8'h77);
    cpu_req(1'b1, 1'b0, 16'hC10A, 8'h00);

    // Set 2 full, way 0 dirty: evict it before refilling with tag 0x183.
    preload(16'hC188, 8'h99, 8'hAA, 8'hBB, 8'hCC);
    exp_wb(16'hC088, 8'h11, 8'h22, 8'h33, 8'h23);
    exp_fill(16'hC188); rd_q.push_back(8'hAA);
    cpu_req(1'b1, 1'b0, 16'hC189, 8'h00);

    rd_q.push_back(8'h88);
    cpu_req(1'b1, 1'b0, 16'hC10B, 8'h00);

    // Refetch the evicted block: the written-back byte must come home.
    exp_fill(16'hC088); rd_q.push_back(8'h23);
    cpu_req(1'b1, 1'b0, 16'hC08B, 8'h00);

    // Write miss allocates into the free way of set 4.
    preload(16'h0290, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    exp_fill(16'h0290);
    cpu_req(1'b0, 1'b1, 16'h0291, 8'h5E);
    rd_q.push_back(8'h5E);
    cpu_req(1'b1, 1'b0, 16'h0291, 8'h00);
    rd_q.push_back(8'hB0);
    cpu_req(1'b1, 1'b0, 16'h0290, 8'h00);
    cpu_req(1'b1, 1'b1, 16'h0292, 8'h77);
    rd_q.push_back(8'h77);
    cpu_req(1'b1, 1'b0, 16'h0292, 8'h00);
    rd_q.push_back(8'hA3);
    cpu_req(1'b1, 1'b0, 16'h0093, 8'h00);

    repeat (3) @(negedge clock);
    chk("rd_q_drained", rd_q.size(), 32'h0);
    chk("mem_q_drained", mem_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
